// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide engine.
// The decoder imports muldiv_op_t from here so operation encodings stay in one place.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// Both datapaths share one 2*WIDTH accumulator; signs are applied once in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      r_state;
  muldiv_op_t         r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_divz;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  muldiv_op_t         w_op;
  logic               w_start_div;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_op        = muldiv_op_t'(op);
  assign w_start_div = op_is_div(w_op);
  assign w_mag_a     = (op_is_signed(w_op) && a[WIDTH-1]) ? -a : a;
  assign w_mag_b     = (op_is_signed(w_op) && b[WIDTH-1]) ? -b : b;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide: remainder in the high half, dividend shifts out of the low half
  // while quotient bits shift in behind it.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = ((r_op == MULT) && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
  assign w_quo  = ((r_op == DIV) && (r_sign_a ^ r_sign_b)) ? -r_acc[WIDTH-1:0]
                                                           : r_acc[WIDTH-1:0];
  assign w_rem  = ((r_op == DIV) && r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH]
                                              : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_divz   <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_op     <= w_op;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= b[WIDTH-1];
            r_opb    <= w_start_div ? w_mag_b : w_mag_a;
            r_cnt    <= CW'(WIDTH - 1);
            if (w_start_div && (b == '0)) begin
              // Divide by zero skips iteration; raw dividend and all-ones go straight to FIX.
              r_divz  <= 1'b1;
              r_acc   <= {a, {WIDTH{1'b1}}};
              r_state <= FIX;
            end else begin
              r_divz  <= 1'b0;
              r_acc   <= {{WIDTH{1'b0}}, (w_start_div ? w_mag_a : w_mag_b)};
              r_state <= ITER;
            end
          end
        end
        ITER: begin
          r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_divz) begin
            r_hi <= r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_acc[WIDTH-1:0];
          end else if (op_is_div(r_op)) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
